// File: rtl/packed_enum_fifo_if.sv
// Beat-level handshake bundle for the packed enum FIFO: one producer-side
// stream (in_*) and one consumer-side stream (out_*), both carrying
// NCH packed W-bit elements per beat.
interface packed_enum_fifo_if #(
    parameter int W   = 4,
    parameter int NCH = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NCH-1:0][W-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [NCH-1:0][W-1:0]   out_data;

    // FIFO side: sinks the producer stream, sources the consumer stream
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Environment side: drives beats in and consumes beats out
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/packed_enum_fifo.sv
// First-word-fall-through FIFO for packed arrays of enum-typed elements.
// Every accepted element is range-checked against ENUM_MAX; illegal values
// are still stored and forwarded, but raise sticky per-channel flags and
// bump a saturating beat error counter.
module packed_enum_fifo #(
    parameter int          W        = 4,
    parameter int          NCH      = 2,
    parameter int          DEPTH    = 4,
    parameter int unsigned ENUM_MAX = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    packed_enum_fifo_if.slave         bus,
    input  logic                      clr_err,
    output logic [$clog2(DEPTH):0]    count,
    output logic [NCH-1:0]            illegal_seen,
    output logic [7:0]                illegal_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [NCH-1:0][W-1:0] beat_t;

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ready_en_q, ready_en_d;
    logic [NCH-1:0]          seen_q, seen_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    in_ready;
    logic                    push;
    logic                    pop;
    logic [NCH-1:0]          ill;
    logic [DEPTH-1:0][NCH-1:0][W-1:0] mem_vec;

    // Handshake and pointer/occupancy next-state; ready comes only from flops
    always_comb begin
        in_ready   = ready_en_q & (count_q != CW'(DEPTH));
        push       = bus.in_valid & in_ready;
        pop        = (count_q != '0) & bus.out_ready;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ready_en_d = 1'b1;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Per-channel unsigned range check on accepted elements
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : gen_chk
            assign ill[gi] = push & (32'(bus.in_data[gi]) > ENUM_MAX);
        end
    endgenerate

    // Sticky flags and saturating counter; a same-cycle event beats clear
    always_comb begin
        seen_d = (clr_err ? '0 : seen_q) | ill;
        cnt_d  = cnt_q;
        if (clr_err)
            cnt_d = (|ill) ? 8'd1 : 8'd0;
        else if ((|ill) && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    // Control and error state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
            seen_q     <= '0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= ready_en_d;
            seen_q     <= seen_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage: one register per entry, written when the write pointer selects it
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_mem
            beat_t entry_q, entry_d;

            // Capture the incoming beat into this slot on push
            always_comb begin
                entry_d = entry_q;
                if (push && (wr_ptr_q == PW'(gi)))
                    entry_d = bus.in_data;
            end

            // Entry register, cleared on reset so out_data reads zero
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_q <= '0;
                else
                    entry_q <= entry_d;
            end

            assign mem_vec[gi] = entry_q;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_vec[rd_ptr_q];
    assign count         = count_q;
    assign illegal_seen  = seen_q;
    assign illegal_cnt   = cnt_q;
endmodule

// File: tb/tb_packed_enum_fifo.sv
// Randomized + directed bench for packed_enum_fifo against a queue model.
module tb_packed_enum_fifo;
    localparam int W        = 4;
    localparam int NCH      = 2;
    localparam int DEPTH    = 4;
    localparam int ENUM_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] count;
    logic [1:0] illegal_seen;
    logic [7:0] illegal_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ready_en;
    bit [1:0]   m_seen;
    int         m_cnt;

    packed_enum_fifo_if #(.W(W), .NCH(NCH)) bus ();

    packed_enum_fifo #(.W(W), .NCH(NCH), .DEPTH(DEPTH), .ENUM_MAX(ENUM_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .clr_err      (clr_err),
        .count        (count),
        .illegal_seen (illegal_seen),
        .illegal_cnt  (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ready_en = 1'b0;
        m_seen     = '0;
        m_cnt      = 0;
    endtask

    // One clock: compare outputs with the model, then advance both
    task automatic cycle();
        bit       push, pop, any;
        bit [1:0] ill;
        bit       exp_rdy;
        logic [7:0] din;
        @(negedge clk);
        exp_rdy = m_ready_en && (q.size() < DEPTH);
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) check("out_data", bus.out_data, q[0]);
        check("count", count, q.size());
        check("illegal_seen", illegal_seen, m_seen);
        check("illegal_cnt", illegal_cnt, m_cnt);
        din  = bus.in_data;
        push = bus.in_valid && exp_rdy;
        pop  = bus.out_ready && (q.size() != 0);
        ill[0] = push && (int'(din[3:0]) > ENUM_MAX);
        ill[1] = push && (int'(din[7:4]) > ENUM_MAX);
        any  = |ill;
        @(posedge clk);
        if (pop) begin
            $display("[TB] pop beat %02h (count before %0d)", q[0], q.size());
            void'(q.pop_front());
        end
        if (push) q.push_back(din);
        m_seen = (clr_err ? 2'b00 : m_seen) | ill;
        if (clr_err) m_cnt = any ? 1 : 0;
        else if (any && m_cnt < 255) m_cnt++;
        m_ready_en = 1'b1;
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        clr_err       = c;
        cycle();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;

        // Reset then single beat
        drive(0, 8'h00, 0, 0);
        drive(1, 8'h21, 0, 0);
        check("single_valid", bus.out_valid, 1);
        check("single_data", bus.out_data, 8'h21);
        check("single_count", count, 1);
        drive(0, 8'h00, 1, 0);
        check("single_empty", bus.out_valid, 0);
        check("single_count0", count, 0);

        // Fill, refuse fifth push, drain in order
        for (int i = 0; i < 4; i++) drive(1, 8'(i * 8'h11), 0, 0);
        check("full_count", count, 4);
        check("full_ready", bus.in_ready, 0);
        drive(1, 8'h12, 0, 0);
        check("refused_count", count, 4);
        check("head0", bus.out_data, 8'h00);
        drive(1, 8'h12, 1, 0);
        check("refused_pop_count", count, 3);
        for (int i = 1; i < 4; i++) begin
            check("drain_order", bus.out_data, 8'(i * 8'h11));
            drive(0, 8'h00, 1, 0);
        end
        check("drained", count, 0);

        // Concurrent push/pop across pointer wrap
        drive(1, 8'h00, 0, 0);
        for (int i = 1; i < 10; i++) begin
            drive(1, 8'(i), 1, 0);
            check("stream_count", count, 1);
        end
        drive(0, 8'h00, 1, 0);

        // Illegal detection
        drive(0, 8'h00, 0, 1);
        drive(1, 8'h52, 1, 0);
        drive(1, 8'h07, 1, 0);
        drive(1, 8'h13, 1, 0);
        check("ill_seen", illegal_seen, 2'b11);
        check("ill_cnt", illegal_cnt, 2);

        // Clear versus same-cycle event, then saturation
        drive(1, 8'h40, 1, 1);
        check("clr_seen", illegal_seen, 2'b10);
        check("clr_cnt", illegal_cnt, 1);
        for (int i = 0; i < 260; i++) drive(1, 8'h44, 1, 0);
        check("sat_cnt", illegal_cnt, 255);
        drive(1, 8'hF0, 1, 0);
        check("sat_hold", illegal_cnt, 255);
        drive(0, 8'h00, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));

        // Reset mid-stream
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 8'hA1 + 8'(i), 0, 0);
        check("pre_rst_count", count, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_data", bus.out_data, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        check("post_rst_empty", bus.out_valid, 0);
        drive(1, 8'h32, 0, 0);
        check("post_rst_head", bus.out_data, 8'h32);
        drive(0, 8'h00, 1, 0);
        check("post_rst_final", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/packed_enum_fifo.md
Name: packed_enum_fifo

Overview:
- Parametrised successor to the packed-array enum port passthrough: carries NCH channels of W-bit enum-typed elements as one packed-array beat, instead of a single 4-bit combinational wire.
- Adds DEPTH-entry first-word-fall-through buffering with valid/ready handshake on both sides.
- Checks every accepted element against the legal enum range, with sticky per-channel flags and a saturating error counter.
- Sits between producer and consumer modules exchanging packed enum arrays across a module boundary.

Parameters:
- W, 4: element (enum) width in bits, >=1.
- NCH, 2: number of packed elements per beat, >=1.
- DEPTH, 4: FIFO entries; a power of two, >=2.
- ENUM_MAX, 0: largest legal element value; any element greater than ENUM_MAX is illegal.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  FIFO can accept a beat.
- in_data  input  NCH*W  packed array [NCH-1:0][W-1:0]; element i is bits [i*W +: W].
- out_valid  output  1  head beat valid.
- out_ready  input  1  consumer accepts the head beat.
- out_data  output  NCH*W  head beat, same packing as in_data.
- count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- clr_err  input  1  synchronous clear of illegal_seen and illegal_cnt.
- illegal_seen  output  NCH  sticky flag per channel: an illegal element was accepted on that channel.
- illegal_cnt  output  8  saturating count of accepted beats that contain at least one illegal element.

Behaviour:
Reset (rst_n low, asynchronous):
- Clears wr_ptr, rd_ptr, count, all storage entries, illegal_seen and illegal_cnt.
- out_valid=0, out_data=0, in_ready=0 while rst_n is low.
- An assertion mid-operation discards all buffered beats immediately.
- in_ready=1 from the first edge after release.

Handshake:
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends on registered state only; there is no combinational path from out_ready.
- When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr] (first-word fall-through).
- Latency: a beat pushed at edge N is visible on out_valid/out_data after edge N.
- in_data and in_valid are ignored when in_ready=0. Inputs are don't-care while their valid is low.
- Push stores in_data at mem[wr_ptr]; wr_ptr advances. Pop advances rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count: +1 on push only; -1 on pop only; unchanged on push and pop together (legal only when 0<count<DEPTH).
- Empty: out_ready is ignored; out_data holds mem[rd_ptr] and is not meaningful.
- Data ordering is strict FIFO per beat. Element order within a beat is preserved bit-exactly.

Legality check (accepted beats only):
- ill[i] = push & (in_data element i > ENUM_MAX), unsigned compare.
- Illegal beats are stored and forwarded unmodified; the check never blocks or drops data.
- illegal_seen[i] <= (clr_err ? 0 : illegal_seen[i]) | ill[i]. A same-cycle event wins over clear.
- illegal_cnt: on clr_err it loads (|ill ? 1 : 0). Otherwise it increments by 1 when |ill, saturating at 255.
- If ENUM_MAX >= 2^W - 1, no element is ever illegal.

Test Plan:
(W=4, NCH=2, DEPTH=4, ENUM_MAX=3 unless noted)
- Reset then single beat: release rst_n, push 0x21 with out_ready=0. Next cycle: out_valid=1, out_data=0x21, count=1. Assert out_ready for one cycle: count=0, out_valid=0.
- Fill and full: push 0x00, 0x11, 0x22, 0x33 with out_ready=0. Then count=4, in_ready=0. A fifth push of 0x12 is refused, including when out_ready=1 in that cycle. Drain order is 0x00, 0x11, 0x22, 0x33.
- Concurrent push/pop with wrap: stream 10 beats 0x00..0x09 (low nibble cycling) with in_valid=out_ready=1 after the first push. count stays 1; output sequence is identical to input; pointers wrap twice.
- Illegal detection: push 0x52 (channel 1 = 5 is illegal), 0x07, then 0x13. Result: illegal_seen=2'b11, illegal_cnt=2, and all beats are forwarded unchanged.
- Clear vs event: with illegal_cnt=2, assert clr_err in the same cycle as pushing 0x40. Next cycle: illegal_seen=2'b10, illegal_cnt=1. Then 260 illegal beats drive illegal_cnt to 255 and it holds there.
- Reset mid-stream: with count=3, pulse rst_n low between edges. Immediately out_valid=0, count=0, in_ready=0 and out_data=0. After release the old beats never appear.
